// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the memory port arbiter: FSM states, port owner,
// default bus widths and the saturating starvation-counter step.
package rv_pipe_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the external
// memory. The arbiter takes the slave view; the surrounding system the master view.
interface mem_port_arbiter_if
  import rv_pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: data has
// fixed priority, fetch wins once it has waited STARVE_LIMIT data grants.
module mem_port_arbiter
  import rv_pipe_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [3:0]        starve_q, starve_d;

    // NOTE: every _d gets its hold value first so no branch can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;

        unique case (state_q)
            IDLE: begin
                if (bus.if_req && (!bus.dm_req || starve_q == LIMIT)) begin
                    state_d  = BUSY_IF;
                    owner_d  = OWN_IF;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = 4'd0;
                end else if (bus.dm_req) begin
                    state_d  = BUSY_DM;
                    owner_d  = OWN_DM;
                    addr_d   = bus.dm_addr;
                    we_d     = bus.dm_we;
                    wdata_d  = bus.dm_wdata;
                    starve_d = bus.if_req ? sat_inc(starve_q, LIMIT) : 4'd0;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ready) begin
                    if_rdata_d = bus.mem_rdata;
                    state_d    = DONE;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ready) begin
                    dm_rdata_d = bus.mem_rdata;
                    state_d    = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            starve_q   <= starve_d;
        end
    end

    // Memory side is driven only from the latched request, never from the live requester.
    assign bus.mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_ack    = (state_q == DONE) && (owner_q == OWN_IF);
    assign bus.dm_ack    = (state_q == DONE) && (owner_q == OWN_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    assign bus.if_stall  = bus.if_req & ~bus.if_ack;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant model pushes the expected owner
// and read data per request; a memory responder with programmable wait states answers.
module tb_mem_port_arbiter;
    import rv_pipe_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int BUDGET       = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          dm;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [31:0] mem_model[logic [31:0]];
    int          mem_delay = 0;
    int          busy_cnt = 0;

    int          obs_cyc, obs_if_stall, obs_dm_stall, obs_busy;
    bit          obs_timeout, obs_dm, obs_both, obs_stable;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic        obs_we;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory: answers after mem_delay wait states; random ready/data while idle must be ignored.
    always @(negedge clk) begin
        if (bus.mem_req && busy_cnt >= mem_delay) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd_word(bus.mem_addr);
            if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
        end else begin
            bus.mem_ready = bus.mem_req ? 1'b0 : 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            if (bus.mem_req) busy_cnt++;
            else busy_cnt = 0;
        end
    end

    // Reference grant rule; returns 1 when data wins.
    function automatic bit model_grant(input bit ifr, input bit dmr);
        if (ifr && (!dmr || model_cnt == STARVE_LIMIT)) begin
            model_cnt = 0;
            return 1'b0;
        end
        model_cnt = !ifr ? 0 : (model_cnt == STARVE_LIMIT) ? model_cnt : model_cnt + 1;
        return 1'b1;
    endfunction

    task automatic push_exp(input bit ifr, input bit dmr);
        exp_t e;
        e.dm    = model_grant(ifr, dmr);
        e.addr  = e.dm ? bus.dm_addr : bus.if_addr;
        e.we    = e.dm ? bus.dm_we : 1'b0;
        e.wdata = e.dm ? bus.dm_wdata : 32'h0;
        e.rdata = rd_word(e.addr);
        sb.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e = '{dm: 1'b0, addr: 32'h0, we: 1'b0, wdata: 32'h0, rdata: 32'h0};
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    // Called at a negedge with requests already driven (that cycle is cycle 0).
    task automatic wait_ack(input int chg_cycle, input logic [31:0] chg_addr);
        obs_timeout = 1'b1; obs_cyc = -1; obs_if_stall = 0; obs_dm_stall = 0;
        obs_busy = 0; obs_stable = 1'b1; obs_both = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (c == chg_cycle) bus.dm_addr = chg_addr;
            #1;
            if (bus.if_stall) obs_if_stall++;
            if (bus.dm_stall) obs_dm_stall++;
            if (bus.mem_req) begin
                obs_busy++;
                if (obs_busy == 1) begin
                    obs_addr = bus.mem_addr; obs_we = bus.mem_we; obs_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== obs_addr || bus.mem_we !== obs_we ||
                             bus.mem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
            end
            if (bus.if_ack || bus.dm_ack) begin
                obs_timeout = 1'b0;
                obs_cyc     = c;
                obs_dm      = bus.dm_ack;
                obs_both    = bus.if_ack && bus.dm_ack;
                obs_rdata   = bus.dm_ack ? bus.dm_rdata : bus.if_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_txn();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] got[8];
        string       nm[8];
        exp_t        e;
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h200; bus.dm_we = 1'b0; bus.dm_wdata = 32'h1111_2222;
        repeat (3) @(negedge clk);
        #1;
        got = '{32'(bus.mem_req), 32'(bus.mem_we), bus.mem_addr, bus.mem_wdata,
                32'(bus.if_ack), 32'(bus.dm_ack), bus.if_rdata, bus.dm_rdata};
        nm  = '{"mem_req", "mem_we", "mem_addr", "mem_wdata", "if_ack", "dm_ack", "if_rdata", "dm_rdata"};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'h0) begin
                errors++; $display("FAIL reset_%s got %h want 0", nm[i], got[i]);
            end
        end
        checks++;
        if ({bus.if_stall, bus.dm_stall} !== 2'b11) begin
            errors++; $display("FAIL reset_stalls got %b want 11", {bus.if_stall, bus.dm_stall});
        end
        @(negedge clk);
        reset = 1'b1;
        push_exp(1'b1, 1'b1);
        wait_ack(-1, 32'h0);
        e = pop_exp();
        checks++;
        if (obs_timeout || obs_dm !== e.dm || obs_cyc !== 2) begin
            errors++; $display("FAIL reset_first_grant got dm=%0b cyc=%0d timeout=%0b want dm=%0b cyc=2",
                               obs_dm, obs_cyc, obs_timeout, e.dm);
        end
        checks++;
        if (obs_rdata !== e.rdata) begin
            errors++; $display("FAIL reset_first_rdata got %h want %h", obs_rdata, e.rdata);
        end
        finish_txn();
    endtask

    task automatic test_single_fetch();
        exp_t e;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        push_exp(1'b1, 1'b0);
        wait_ack(-1, 32'h0);
        e = pop_exp();
        checks++;
        if (obs_timeout || obs_dm !== e.dm || obs_cyc !== 2) begin
            errors++; $display("FAIL fetch_ack got dm=%0b cyc=%0d timeout=%0b want dm=%0b cyc=2",
                               obs_dm, obs_cyc, obs_timeout, e.dm);
        end
        checks++;
        if (obs_rdata !== e.rdata) begin
            errors++; $display("FAIL fetch_rdata got %h want %h", obs_rdata, e.rdata);
        end
        checks++;
        if (obs_if_stall !== 2) begin
            errors++; $display("FAIL fetch_stall_cycles got %0d want 2", obs_if_stall);
        end
        checks++;
        if (obs_busy !== 1 || obs_addr !== e.addr || obs_we !== e.we) begin
            errors++; $display("FAIL fetch_mem_bus got busy=%0d addr=%h we=%b want busy=1 addr=%h we=%b",
                               obs_busy, obs_addr, obs_we, e.addr, e.we);
        end
        finish_txn();
    endtask

    task automatic test_store();
        exp_t e;
        mem_delay = 3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
        push_exp(1'b0, 1'b1);
        wait_ack(-1, 32'h0);
        e = pop_exp();
        checks++;
        if (obs_timeout || obs_dm !== e.dm || obs_cyc !== 5) begin
            errors++; $display("FAIL store_ack got dm=%0b cyc=%0d timeout=%0b want dm=%0b cyc=5",
                               obs_dm, obs_cyc, obs_timeout, e.dm);
        end
        checks++;
        if (obs_busy !== 4 || !obs_stable) begin
            errors++; $display("FAIL store_hold got busy=%0d stable=%0b want busy=4 stable=1", obs_busy, obs_stable);
        end
        checks++;
        if (obs_addr !== e.addr || obs_we !== e.we || obs_wdata !== e.wdata) begin
            errors++; $display("FAIL store_mem_bus got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                               obs_addr, obs_we, obs_wdata, e.addr, e.we, e.wdata);
        end
        checks++;
        if (obs_dm_stall !== 5) begin
            errors++; $display("FAIL store_stall_cycles got %0d want 5", obs_dm_stall);
        end
        mem_delay = 0;
        bus.dm_we = 1'b0;
        finish_txn();
    endtask

    task automatic test_starvation();
        exp_t e;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h200; bus.dm_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push_exp(1'b1, 1'b1);
            wait_ack(-1, 32'h0);
            e = pop_exp();
            checks++;
            if (obs_timeout || obs_dm !== e.dm || obs_both) begin
                errors++; $display("FAIL starve_grant_%0d got dm=%0b both=%0b timeout=%0b want dm=%0b",
                                   k, obs_dm, obs_both, obs_timeout, e.dm);
            end
            checks++;
            if (obs_rdata !== e.rdata || obs_cyc !== 2) begin
                errors++; $display("FAIL starve_data_%0d got rdata=%h cyc=%0d want rdata=%h cyc=2",
                                   k, obs_rdata, obs_cyc, e.rdata);
            end
            @(negedge clk);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_hold();
        exp_t e;
        mem_delay = 2;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
        push_exp(1'b0, 1'b1);
        wait_ack(1, 32'h80);
        e = pop_exp();
        checks++;
        if (obs_timeout || obs_cyc !== 4) begin
            errors++; $display("FAIL hold_ack got cyc=%0d timeout=%0b want cyc=4", obs_cyc, obs_timeout);
        end
        checks++;
        if (obs_addr !== e.addr || !obs_stable) begin
            errors++; $display("FAIL hold_addr got addr=%h stable=%0b want addr=%h stable=1",
                               obs_addr, obs_stable, e.addr);
        end
        checks++;
        if (obs_rdata !== e.rdata) begin
            errors++; $display("FAIL hold_rdata got %h want %h", obs_rdata, e.rdata);
        end
        mem_delay = 0;
        finish_txn();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        mem_delay = 50;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        @(negedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL midreset_busy got mem_req=%b want 1", bus.mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_ack !== 1'b0) begin
            errors++; $display("FAIL midreset_abort got mem_req=%b addr=%h if_ack=%b want 0 0 0",
                               bus.mem_req, bus.mem_addr, bus.if_ack);
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        reset = 1'b1;
        model_cnt = 0;
        mem_delay = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.if_ack || bus.dm_ack || bus.mem_req) acks++;
            @(negedge clk);
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL midreset_no_ack got %0d ack/req cycles want 0", acks);
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        reset = 1'b0;
        mem_model[32'h10] = 32'h0050_0093;
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_store();
        test_starvation();
        test_addr_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). Holds each requester with a stall until its transaction completes, fixed priority to data accesses with a starvation guard for fetch. Sits between the pipeline's fetch/memory stages and the external memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (range 1-15)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  fetch must hold PC and IF/ID
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data
- dm_stall  out  1  memory stage must hold
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes current request this cycle

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: arbitrate. dm_req wins unless if_req=1 and starve_cnt==STARVE_LIMIT, then IF wins. No request -> stay IDLE.
- On grant: latch addr, we (0 for IF), wdata into registers; go to BUSY_IF/BUSY_DM. Requester-side changes during BUSY are ignored.
- BUSY_x: mem_req=1, mem_* driven from latched registers. mem_ready=1 -> register mem_rdata into x_rdata, go to DONE with owner recorded. mem_ready=0 -> stay.
- DONE: x_ack=1 for owner only; go to IDLE unconditionally. Requests are sampled only in IDLE.
- starve_cnt (4-bit): on DM grant with if_req=1, increments (saturates at STARVE_LIMIT); on IF grant, clears; on DM grant with if_req=0, clears.
- if_stall = if_req & ~if_ack; dm_stall = dm_req & ~dm_ack (combinational).
- Store: x_rdata after a store ack is the captured mem_rdata, don't-care to requester.

## Timing
- Reset (async assert, sync-to-clock release): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, starve_cnt=0. Reset mid-transaction abandons the memory access; no ack issued.
- Minimum latency: request seen in IDLE at cycle 0 -> mem_req=1 at cycle 1 -> with mem_ready at cycle 1, ack at cycle 2 -> IDLE cycle 3. Back-to-back transactions every 3 cycles at best.
- Each extra mem_ready=0 cycle in BUSY adds one cycle.
- Simultaneous if_req and dm_req: DM first; IF served next unless another DM arrives and starve_cnt < STARVE_LIMIT.
- Requester must deassert req in the cycle after ack, else it is treated as a new request in IDLE.
- mem_ready while not BUSY is ignored.

## Structure
- Shared package rv_pipe_pkg: arbiter state enum (IDLE, BUSY_IF, BUSY_DM, DONE), owner enum (OWN_IF, OWN_DM), default ADDR_W/DATA_W constants.
- Single module; no sub-module required. Starvation counter stays inline.

## Test plan
- Reset: hold reset=0 with both reqs high -> mem_req=0, acks=0, all outputs 0; release -> DM granted first.
- Single fetch, if_addr=0x10, mem_ready at first BUSY cycle, mem_rdata=0x00500093 -> if_ack at cycle 2 with if_rdata=0x00500093, if_stall high cycles 0-1.
- Store dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we=1, mem_addr=0x40 held 4 cycles, dm_ack at cycle 5.
- Both reqs every idle slot, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...; starve_cnt clears on IF grant.
- Requester changes dm_addr 0x40->0x80 during BUSY_DM -> mem_addr stays 0x40 until ack.
- Reset asserted during BUSY_IF with mem_ready low -> next cycle IDLE, mem_req=0, no if_ack ever issued for that request.
